memd_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - Port 0: the core control FSM (PUSH/POP traffic).
  - Port 1: a loader/debug port.
- Round-robin arbitration with a req/done handshake.
- Sequences every read over the memory's fixed read latency, so requesters never count memory cycles.
- Sits between the control FSM/debug logic and the data memory (rd_memd/wr_memd interface).

---
 rtl/memd_arbiter_if.sv | 42 ++++
 rtl/memd_arbiter.sv | 109 ++++++++++
 tb/tb_memd_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memd_arbiter_if.sv
// Requester and data-memory signal bundle for memd_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface memd_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Handshake: req/we/addr/wdata are held until the one-cycle gnt pulse;
  // done pulses once per accepted transaction, rdata valid from done on.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, done0, rdata0, gnt1, done1, rdata1,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memd_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the
// control FSM (port 0) and the loader/debug port (port 1).
module memd_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  memd_arbiter_if.slave  bus,
  output logic           busy,
  output logic           owner,
  output logic [1:0]     state_dbg
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       we_l;
  logic       pick;
  logic       sel_we;

  assign state_dbg = state;

  // On a tie the requester that did not own the last grant wins.
  always_comb begin
    pick   = (bus.req0 && bus.req1) ? ~owner : bus.req1;
    sel_we = pick ? bus.we1 : bus.we0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= 1'b1;
      cnt           <= 3'd0;
      we_l          <= 1'b0;
      busy          <= 1'b0;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.gnt0  <= 1'b0;
      bus.gnt1  <= 1'b0;
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner         <= pick;
            we_l          <= sel_we;
            bus.mem_addr  <= pick ? bus.addr1 : bus.addr0;
            bus.mem_wdata <= pick ? bus.wdata1 : bus.wdata0;
            bus.mem_wr    <= sel_we;
            bus.mem_rd    <= ~sel_we;
            bus.gnt0      <= ~pick;
            bus.gnt1      <= pick;
            busy          <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_l) begin
            bus.mem_wr <= 1'b0;
            bus.done0  <= ~owner;
            bus.done1  <= owner;
            state      <= DONE;
          end else if (RD_LAT > 1) begin
            cnt   <= LAT_M1;
            state <= WAIT;
          end else begin
            if (owner) bus.rdata1 <= bus.mem_rdata;
            else       bus.rdata0 <= bus.mem_rdata;
            bus.mem_rd <= 1'b0;
            bus.done0  <= ~owner;
            bus.done1  <= owner;
            state      <= DONE;
          end
        end
        WAIT: begin
          // mem_rd stays high here so it spans exactly RD_LAT cycles in total.
          if (cnt == 3'd1) begin
            if (owner) bus.rdata1 <= bus.mem_rdata;
            else       bus.rdata0 <= bus.mem_rdata;
            bus.mem_rd <= 1'b0;
            bus.done0  <= ~owner;
            bus.done1  <= owner;
            state      <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memd_arbiter.sv
// Directed bench for memd_arbiter: an RD_LAT=2 instance with a read-latency
// memory model and scoreboard, plus an RD_LAT=1 instance.
module tb_memd_arbiter;
  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       busy_a, owner_a, busy_b, owner_b;
  logic [1:0] state_a, state_b;

  int checks = 0;
  int errors = 0;

  // Entry: {port, is_read, expected read data}
  logic [17:0] exp_q[$];
  logic [17:0] e;

  logic [15:0] mem_a [0:2047];
  logic [15:0] mem_b [0:2047];
  int          run_a = 0;
  int          run_b = 0;

  memd_arbiter_if #(.ADDR_W(11), .DATA_W(16)) bus_a ();
  memd_arbiter_if #(.ADDR_W(11), .DATA_W(16)) bus_b ();

  memd_arbiter #(.ADDR_W(11), .DATA_W(16), .RD_LAT(2)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a),
    .busy(busy_a), .owner(owner_a), .state_dbg(state_a)
  );

  memd_arbiter #(.ADDR_W(11), .DATA_W(16), .RD_LAT(1)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b),
    .busy(busy_b), .owner(owner_b), .state_dbg(state_b)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // Memory models: data only appears once mem_rd has been held RD_LAT cycles.
  always @(posedge clk) begin
    if (bus_a.mem_wr) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
    run_a <= bus_a.mem_rd ? run_a + 1 : 0;
    if (bus_b.mem_wr) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
    run_b <= bus_b.mem_rd ? run_b + 1 : 0;
  end

  assign bus_a.mem_rdata = (bus_a.mem_rd && run_a == 1) ? mem_a[bus_a.mem_addr] : 16'hDEAD;
  assign bus_b.mem_rdata = (bus_b.mem_rd && run_b == 0) ? mem_b[bus_b.mem_addr] : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected transaction.
  always @(negedge clk) begin
    if (!rst_a) begin
      chk("mem_excl", 32'(bus_a.mem_rd & bus_a.mem_wr), 32'd0);
      if (bus_a.done0 || bus_a.done1) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_port", 32'(bus_a.done1), 32'(e[17]));
          chk("sb_one_done", 32'(bus_a.done0 ^ bus_a.done1), 32'd1);
          if (e[16])
            chk("sb_rdata", 32'(e[17] ? bus_a.rdata1 : bus_a.rdata0), 32'(e[15:0]));
        end
      end
    end
  end

  // Driver: full transaction on instance A, bounded waits for gnt and done.
  task automatic xact_a(input logic port, input logic we, input logic [10:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_rd);
    logic ok;
    if (port) begin
      bus_a.req1 = 1'b1; bus_a.we1 = we; bus_a.addr1 = addr; bus_a.wdata1 = wd;
    end else begin
      bus_a.req0 = 1'b1; bus_a.we0 = we; bus_a.addr0 = addr; bus_a.wdata0 = wd;
    end
    exp_q.push_back({port, ~we, (we ? 16'h0000 : exp_rd)});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? bus_a.gnt1 : bus_a.gnt0) begin ok = 1'b1; break; end
    end
    chk("xact_gnt", 32'(ok), 32'd1);
    if (port) bus_a.req1 = 1'b0; else bus_a.req0 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? bus_a.done1 : bus_a.done0) begin ok = 1'b1; break; end
    end
    chk("xact_done", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  int ng;

  initial begin
    bus_a.req0 = 0; bus_a.we0 = 0; bus_a.addr0 = '0; bus_a.wdata0 = '0;
    bus_a.req1 = 0; bus_a.we1 = 0; bus_a.addr1 = '0; bus_a.wdata1 = '0;
    bus_b.req0 = 0; bus_b.we0 = 0; bus_b.addr0 = '0; bus_b.wdata0 = '0;
    bus_b.req1 = 0; bus_b.we1 = 0; bus_b.addr1 = '0; bus_b.wdata1 = '0;
    @(negedge clk); @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy",   32'(busy_a), 32'd0);
    chk("rst_owner",  32'(owner_a), 32'd1);
    chk("rst_state",  32'(state_a), 32'd0);
    chk("rst_gnt",    32'({bus_a.gnt0, bus_a.gnt1, bus_a.done0, bus_a.done1}), 32'd0);
    chk("rst_mem_en", 32'({bus_a.mem_rd, bus_a.mem_wr}), 32'd0);
    chk("rst_rdata",  32'({bus_a.rdata0, bus_a.rdata1}), 32'd0);
    chk("rst_maddr",  32'(bus_a.mem_addr), 32'd0);

    // Write 0xBEEF to 0x005 from port 0
    bus_a.req0 = 1; bus_a.we0 = 1; bus_a.addr0 = 11'h005; bus_a.wdata0 = 16'hBEEF;
    exp_q.push_back({1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    chk("wr_gnt0",   32'(bus_a.gnt0), 32'd1);
    chk("wr_mem_wr", 32'(bus_a.mem_wr), 32'd1);
    chk("wr_mem_rd", 32'(bus_a.mem_rd), 32'd0);
    chk("wr_addr",   32'(bus_a.mem_addr), 32'h005);
    chk("wr_wdata",  32'(bus_a.mem_wdata), 32'hBEEF);
    chk("wr_owner",  32'(owner_a), 32'd0);
    bus_a.req0 = 0; bus_a.wdata0 = 16'h0000;
    @(negedge clk);
    chk("wr_done0",  32'(bus_a.done0), 32'd1);
    chk("wr_wr_off", 32'(bus_a.mem_wr), 32'd0);
    @(negedge clk);
    chk("wr_idle",   32'(busy_a), 32'd0);

    // Port 1 reads 0x005 back, RD_LAT=2
    bus_a.req1 = 1; bus_a.we1 = 0; bus_a.addr1 = 11'h005;
    exp_q.push_back({1'b1, 1'b1, 16'hBEEF});
    @(negedge clk);
    chk("rd_gnt1",   32'(bus_a.gnt1), 32'd1);
    chk("rd_rd_t1",  32'(bus_a.mem_rd), 32'd1);
    chk("rd_addr",   32'(bus_a.mem_addr), 32'h005);
    chk("rd_owner",  32'(owner_a), 32'd1);
    bus_a.req1 = 0;
    @(negedge clk);
    chk("rd_rd_t2",  32'(bus_a.mem_rd), 32'd1);
    chk("rd_nodone", 32'(bus_a.done1), 32'd0);
    @(negedge clk);
    chk("rd_done1",  32'(bus_a.done1), 32'd1);
    chk("rd_rd_off", 32'(bus_a.mem_rd), 32'd0);
    chk("rd_rdata1", 32'(bus_a.rdata1), 32'hBEEF);
    chk("rd_rdata0", 32'(bus_a.rdata0), 32'h0);
    @(negedge clk);

    // More memory contents via the arbiter
    xact_a(1'b1, 1'b1, 11'h006, 16'h1111, 16'h0);
    xact_a(1'b0, 1'b1, 11'h007, 16'h7777, 16'h0);
    xact_a(1'b0, 1'b0, 11'h006, 16'h0, 16'h1111);

    // Fairness: both ports request continuously after reset
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 11'h005;
    bus_a.req1 = 1; bus_a.we1 = 0; bus_a.addr1 = 11'h006;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({1'b0, 1'b1, 16'hBEEF});
      exp_q.push_back({1'b1, 1'b1, 16'h1111});
    end
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (bus_a.gnt0 || bus_a.gnt1) begin
        chk("fair_gnt_port", 32'(bus_a.gnt1), 32'(ng % 2));
        chk("fair_owner",    32'(owner_a), 32'(ng % 2));
        ng++;
        if (ng == 4) begin bus_a.req0 = 0; bus_a.req1 = 0; end
      end
    end
    chk("fair_count", 32'(ng), 32'd4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy_a) break;
    end
    chk("fair_idle", 32'(busy_a), 32'd0);

    // Port 0 read, req dropped and inputs changed right after gnt0
    bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 11'h007;
    exp_q.push_back({1'b0, 1'b1, 16'h7777});
    @(negedge clk);
    chk("drop_gnt0", 32'(bus_a.gnt0), 32'd1);
    chk("drop_rd1",  32'(bus_a.mem_rd), 32'd1);
    bus_a.req0 = 0; bus_a.we0 = 1; bus_a.addr0 = 11'h000;
    @(negedge clk);
    chk("drop_rd2",  32'(bus_a.mem_rd), 32'd1);
    chk("drop_addr", 32'(bus_a.mem_addr), 32'h007);
    chk("drop_wr",   32'(bus_a.mem_wr), 32'd0);
    @(negedge clk);
    chk("drop_done0", 32'(bus_a.done0), 32'd1);
    chk("drop_rd3",   32'(bus_a.mem_rd), 32'd0);
    @(negedge clk);
    chk("drop_idle",  32'(busy_a), 32'd0);
    bus_a.we0 = 0;

    // Reset during WAIT abandons the read
    bus_a.req0 = 1; bus_a.we0 = 0; bus_a.addr0 = 11'h005;
    @(negedge clk);
    chk("abort_gnt0", 32'(bus_a.gnt0), 32'd1);
    bus_a.req0 = 0;
    @(negedge clk);
    chk("abort_wait", 32'(state_a), 32'd2);
    chk("abort_rd",   32'(bus_a.mem_rd), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("abort_state", 32'(state_a), 32'd0);
    chk("abort_rd_off", 32'(bus_a.mem_rd), 32'd0);
    chk("abort_nodone", 32'(bus_a.done0), 32'd0);
    chk("abort_rdata0", 32'(bus_a.rdata0), 32'd0);
    chk("abort_owner",  32'(owner_a), 32'd1);
    @(negedge clk);
    chk("abort_nodone2", 32'(bus_a.done0), 32'd0);
    xact_a(1'b1, 1'b0, 11'h006, 16'h0, 16'h1111);
    chk("post_owner", 32'(owner_a), 32'd1);

    // RD_LAT=1 instance: write then read 0x3FF
    bus_b.req0 = 1; bus_b.we0 = 1; bus_b.addr0 = 11'h3FF; bus_b.wdata0 = 16'h1234;
    @(negedge clk);
    chk("b_wr_gnt", 32'(bus_b.gnt0 & bus_b.mem_wr), 32'd1);
    bus_b.req0 = 0;
    @(negedge clk);
    chk("b_wr_done", 32'(bus_b.done0), 32'd1);
    @(negedge clk);
    bus_b.req0 = 1; bus_b.we0 = 0; bus_b.addr0 = 11'h3FF;
    @(negedge clk);
    chk("b_rd_gnt", 32'(bus_b.gnt0), 32'd1);
    chk("b_rd_t1",  32'(bus_b.mem_rd), 32'd1);
    bus_b.req0 = 0;
    @(negedge clk);
    chk("b_rd_done",  32'(bus_b.done0), 32'd1);
    chk("b_rd_off",   32'(bus_b.mem_rd), 32'd0);
    chk("b_rd_rdata", 32'(bus_b.rdata0), 32'h1234);
    @(negedge clk);
    chk("b_idle", 32'(busy_b), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
